// File: rtl/fxp_seq_divider_pkg.sv
// Shared fixed-point divider definitions: FSM state encoding, default Q-format
// constants and saturation limits for the default word width.
package fxp_seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int FXP_W    = 36;
    localparam int FXP_FRAC = 10;

    localparam logic [FXP_W-1:0] FXP_SAT_MAX = {1'b0, {(FXP_W-1){1'b1}}};
    localparam logic [FXP_W-1:0] FXP_SAT_MIN = {1'b1, {(FXP_W-1){1'b0}}};

endpackage

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step: shift in a numerator bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module fxp_div_step #(
    parameter int W = 36
) (
    input  logic [W:0] rem,
    input  logic       nbit,
    input  logic [W:0] dvs,
    output logic [W:0] rem_nxt,
    output logic       qbit
);

    logic [W+1:0] part_s;
    logic [W+1:0] diff_s;

    // Trial subtraction; the borrow bit decides restore vs. keep.
    always_comb begin
        part_s  = {rem, nbit};
        diff_s  = part_s - {1'b0, dvs};
        qbit    = ~diff_s[W+1];
        if (qbit) begin
            rem_nxt = diff_s[W:0];
        end else begin
            rem_nxt = part_s[W:0];
        end
    end

endmodule

// File: rtl/fxp_seq_divider.sv
// Sequential signed fixed-point divider: quotient = (dividend << FRAC) / divisor.
// Define DIV_ROUND_EN for round-half-away-from-zero (one extra guard iteration).
module fxp_seq_divider
    import fxp_seq_divider_pkg::*;
#(
    parameter int W    = FXP_W,
    parameter int FRAC = FXP_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic         dz,
    output logic         ovf
);

`ifdef DIV_ROUND_EN
    localparam int ITER = W + FRAC + 1;
`else
    localparam int ITER = W + FRAC;
`endif
    localparam int SH = ITER - W;
    localparam int CW = $clog2(ITER + 1);
    localparam int QW = W + FRAC + 1;

    localparam logic [QW-1:0] POS_LIM = {{(FRAC+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic [QW-1:0] NEG_LIM = {{(FRAC+1){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SAT_MIN = {1'b1, {(W-1){1'b0}}};

    div_state_e state_r, state_nxt_s;

    logic [ITER-1:0] nq_r;
    logic [W:0]      rem_r;
    logic [W:0]      dvs_r;
    logic [CW-1:0]   cnt_r;
    logic            sign_r;
    logic            dsgn_r;
    logic [W-1:0]    quotient_r;
    logic            dz_r;
    logic            ovf_r;

    logic [W:0]      dd_mag_s;
    logic [W:0]      dv_mag_s;
    logic [W:0]      rem_nxt_s;
    logic            qbit_s;
    logic [QW-1:0]   qm_s;
    logic [W-1:0]    fix_q_s;
    logic            fix_ovf_s;

    function automatic logic [W:0] mag_of(input logic [W-1:0] v);
        logic [W:0] ext;
        ext = {v[W-1], v};
        if (v[W-1]) begin
            mag_of = ~ext + {{W{1'b0}}, 1'b1};
        end else begin
            mag_of = ext;
        end
    endfunction

    assign dd_mag_s = mag_of(dividend);
    assign dv_mag_s = mag_of(divisor);

    fxp_div_step #(.W(W)) u_step (
        .rem     (rem_r),
        .nbit    (nq_r[ITER-1]),
        .dvs     (dvs_r),
        .rem_nxt (rem_nxt_s),
        .qbit    (qbit_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: if (in_valid) state_nxt_s = ST_CALC; else state_nxt_s = ST_IDLE;
            ST_CALC: if (cnt_r == CW'(ITER)) state_nxt_s = ST_FIX; else state_nxt_s = ST_CALC;
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: if (out_ready) state_nxt_s = ST_IDLE; else state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Magnitude rounding, sign application and saturation for the FIX state.
    always_comb begin
`ifdef DIV_ROUND_EN
        qm_s = {1'b0, nq_r[ITER-1:1]} + {{(QW-1){1'b0}}, nq_r[0]};
`else
        qm_s = {1'b0, nq_r};
`endif
        fix_ovf_s = 1'b0;
        if (dvs_r == {(W+1){1'b0}}) begin
            fix_q_s = dsgn_r ? SAT_MIN : SAT_MAX;
        end else if (!sign_r && (qm_s > POS_LIM)) begin
            fix_q_s   = SAT_MAX;
            fix_ovf_s = 1'b1;
        end else if (sign_r && (qm_s > NEG_LIM)) begin
            fix_q_s   = SAT_MIN;
            fix_ovf_s = 1'b1;
        end else if (sign_r) begin
            fix_q_s = ~qm_s[W-1:0] + {{(W-1){1'b0}}, 1'b1};
        end else begin
            fix_q_s = qm_s[W-1:0];
        end
    end

    // Datapath: operand capture, one division step per CALC cycle, result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nq_r       <= {ITER{1'b0}};
            rem_r      <= {(W+1){1'b0}};
            dvs_r      <= {(W+1){1'b0}};
            cnt_r      <= {CW{1'b0}};
            sign_r     <= 1'b0;
            dsgn_r     <= 1'b0;
            quotient_r <= {W{1'b0}};
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        nq_r   <= ITER'({dd_mag_s, {SH{1'b0}}});
                        rem_r  <= {(W+1){1'b0}};
                        dvs_r  <= dv_mag_s;
                        cnt_r  <= {CW{1'b0}};
                        sign_r <= dividend[W-1] ^ divisor[W-1];
                        dsgn_r <= dividend[W-1];
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_CALC: begin
                    if (cnt_r != CW'(ITER)) begin
                        nq_r  <= {nq_r[ITER-2:0], qbit_s};
                        rem_r <= rem_nxt_s;
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_FIX: begin
                    quotient_r <= fix_q_s;
                    dz_r       <= (dvs_r == {(W+1){1'b0}});
                    ovf_r      <= fix_ovf_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign quotient = quotient_r;
    assign dz       = dz_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Scoreboard bench for fxp_seq_divider (W=36, FRAC=10); honours DIV_ROUND_EN.
module tb_fxp_seq_divider;

    localparam int W    = 36;
    localparam int FRAC = 10;
`ifdef DIV_ROUND_EN
    localparam int LAT = W + FRAC + 3;
`else
    localparam int LAT = W + FRAC + 2;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic         dz;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic         dz;
    logic         ovf;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    fxp_seq_divider #(.W(W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Independent reference: 64-bit integer division with truncation or rounding.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb_, ma, mb, qm, lim;
        logic   neg;
        logic [63:0] qv;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        neg = (sa < 0) ^ (sb_ < 0);
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (sb_ == 0) begin
            e.dz = 1'b1;
            qv   = (sa >= 0) ? 64'h0000_0007_FFFF_FFFF : 64'hFFFF_FFF8_0000_0000;
        end else begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb_ < 0) ? -sb_ : sb_;
`ifdef DIV_ROUND_EN
            qm = ((ma <<< (FRAC + 1)) / mb + 1) >>> 1;
`else
            qm = (ma <<< FRAC) / mb;
`endif
            lim = neg ? 64'sd34359738368 : 64'sd34359738367;
            if (qm > lim) begin
                e.ovf = 1'b1;
                qm    = lim;
            end
            qv = neg ? -qm : qm;
        end
        e.q = qv[W-1:0];
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int   cyc;
        exp_t e;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'({$urandom(), $urandom()});
        divisor  = W'($urandom());
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(LAT));
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", 64'(quotient), 64'(e.q));
            chk("dz", 64'(dz), 64'(e.dz));
            chk("ovf", 64'(ovf), 64'(e.ovf));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                dividend = W'($urandom());
                divisor  = W'($urandom());
                @(negedge clk);
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_quotient", 64'(quotient), 64'(e.q));
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
        end else begin
            sb.delete();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_flags", 64'({dz, ovf}), 64'd0);
        rst_n = 1'b1;

        run_op(36'd3072, 36'd2048, 0);
        chk("vec_1536", 64'(quotient), 64'd1536);
        run_op(-36'sd3072, 36'd2048, 0);
        run_op(-36'sd3072, -36'sd2048, 0);
        run_op(36'd5, 36'd0, 0);
        run_op(-36'sd5, 36'd0, 0);
        run_op(36'h7_FFFF_FFFF, 36'd1, 0);
        run_op(36'h8_0000_0000, -36'sd1, 0);
        run_op(36'h8_0000_0000, 36'd1, 0);
        run_op(36'd2048, 36'd3072, 0);
        run_op(-36'sd2048, 36'd3072, 0);
        run_op(36'd1, 36'd2048, 0);
        run_op(36'd3, -36'sd2048, 0);
        run_op(36'd1000, 36'd7, 5);

        for (int n = 0; n < 16; n++) begin
            if (n < 8) begin
                run_op(W'($urandom()), W'($urandom_range(1, 65535)) ^ {W{n[0]}}, n % 3);
            end else begin
                run_op(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 0);
            end
        end

        // Abort an operation part-way through CALC.
        @(negedge clk);
        dividend = 36'd3072;
        divisor  = 36'd2048;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_quotient", 64'(quotient), 64'd0);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);

        run_op(36'd2048, 36'd3072, 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fxp_seq_divider.md
FXP_SEQ_DIVIDER -- requirements
Module: fxp_seq_divider

Interface
REQ-001 Parameter W, default 36, operand and result width in bits (two's complement).
REQ-002 Parameter FRAC, default 10, fractional bits of the result (Q-format shift applied to dividend).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  dividend/divisor presented.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 dividend  input  W  signed numerator.
REQ-008 divisor  input  W  signed denominator.
REQ-009 out_valid  output  1  quotient and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  W  signed result = (dividend * 2^FRAC) / divisor.
REQ-012 dz  output  1  divide-by-zero occurred for this result.
REQ-013 ovf  output  1  quotient saturated due to range overflow.

Function
REQ-014 FSM states IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-015 IDLE: in_ready=1; in_valid=1 captures operand magnitudes (W+1 bits, so -2^(W-1) is exact) and result sign = XOR of operand signs, then moves to CALC.
REQ-016 CALC: radix-2 restoring division, one quotient bit per cycle, W+FRAC iterations over dividend magnitude shifted left FRAC; iteration counter width clog2(W+FRAC+1).
REQ-017 FIX: apply sign (negate if sign set), saturate, register quotient/dz/ovf; then DONE.
REQ-018 DONE: out_valid=1; quotient/dz/ovf held stable until out_ready=1, then IDLE next cycle.
REQ-019 Latency: accept edge to out_valid asserted = W+FRAC+2 cycles, independent of operand values.
REQ-020 Truncation toward zero (without macro of REQ-027); negative and positive results symmetric in magnitude.
REQ-021 Divisor 0: dz=1, ovf=0, quotient = 2^(W-1)-1 if dividend >= 0, else -2^(W-1); same latency as normal operation.
REQ-022 Magnitude exceeding 2^(W-1)-1 (positive) or 2^(W-1) (negative): ovf=1, quotient saturated to that limit.
REQ-023 in_valid ignored outside IDLE; in_ready=0 in CALC, FIX, DONE; no operation is queued.
REQ-024 Operands sampled only at the accept edge; later input changes do not affect the in-flight result.

Reset
REQ-025 rst_n=0 at a clock edge: state IDLE, in_ready=1, out_valid=0, quotient=0, dz=0, ovf=0, counter and remainder cleared.
REQ-026 Reset mid-operation (CALC/FIX/DONE) aborts the operation; no out_valid for it is ever produced.

Configuration
REQ-027 Macro DIV_ROUND_EN: defined -> one extra CALC iteration yields a guard bit, result rounded half away from zero, latency W+FRAC+3; saturation applied after rounding (round-up into overflow sets ovf).
REQ-028 DIV_ROUND_EN undefined -> truncation per REQ-020, latency per REQ-019, no guard-bit logic present.

Structure
REQ-029 Shared package holds the FSM state enum, default W/FRAC constants and saturation limit constants, reused by other fixed-point eigenvalue blocks.
REQ-030 One sub-module fxp_div_step: combinational single restoring-division step (remainder in, divisor in, next remainder, quotient bit out), instantiated once inside CALC.

Verification (W=36, FRAC=10)
REQ-031 dividend=3072, divisor=2048 -> quotient=1536, dz=0, ovf=0, out_valid exactly 48 cycles after accept.
REQ-032 dividend=-3072, divisor=2048 -> quotient=-1536; dividend=-3072, divisor=-2048 -> quotient=1536.
REQ-033 dividend=5, divisor=0 -> quotient=2^35-1, dz=1; dividend=-5, divisor=0 -> quotient=-2^35, dz=1.
REQ-034 dividend=2^35-1, divisor=1 -> quotient=2^35-1, ovf=1; dividend=-2^35, divisor=-1 -> quotient=2^35-1, ovf=1.
REQ-035 dividend=2048, divisor=3072 -> quotient=682 (macro off) / 683 (macro on, 49-cycle latency).
REQ-036 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, new operation accepted only after release; rst_n=0 mid-CALC -> IDLE, out_valid never asserted.
